// File: rtl/pipe_skid_stage.sv
// Two-slot skid buffer for a pipeline stage boundary. The MAIN slot drives the outputs and
// the SKID slot catches the one extra entry that can arrive while downstream stalls. in_ready
// is registered, so upstream never sees a combinational path from out_ready.
module pipe_skid_stage #(
  parameter int unsigned PAYLOAD_W = 44,
  parameter int unsigned RD_W      = 5,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_flush,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [PAYLOAD_W-1:0] i_in_data,
  input  logic [RD_W-1:0]      i_in_rd,
  input  logic                 i_in_wen,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [PAYLOAD_W-1:0] o_out_data,
  output logic [RD_W-1:0]      o_out_rd,
  output logic                 o_out_wen,
  output logic [1:0]           o_occupancy,
  output logic [CNT_W-1:0]     o_stall_cnt
);

  typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StTwo = 2'd2} state_e;

  state_e                 r_state;
  logic                   r_in_ready;
  logic                   r_main_vld;
  logic [PAYLOAD_W-1:0]   r_main_data;
  logic [RD_W-1:0]        r_main_rd;
  logic                   r_main_wen;
  logic                   r_skid_vld;
  logic [PAYLOAD_W-1:0]   r_skid_data;
  logic [RD_W-1:0]        r_skid_rd;
  logic                   r_skid_wen;
  logic [CNT_W-1:0]       r_stall_cnt;

  state_e                 w_state_d;
  logic                   w_accept;
  logic                   w_pop;
  logic                   w_main_load;
  logic                   w_main_from_skid;
  logic                   w_skid_load;

  assign w_accept = i_in_valid && r_in_ready;
  assign w_pop    = r_main_vld && i_out_ready;

  // Next-state and slot-load decode; flush overrides everything.
  always_comb begin
    w_state_d        = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (i_flush) begin
      w_state_d = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            w_main_load = 1'b1;
            w_state_d   = StOne;
          end
        end
        StOne: begin
          if (w_accept && w_pop) begin
            w_main_load = 1'b1;
          end else if (w_pop) begin
            w_state_d = StEmpty;
          end else if (w_accept) begin
            w_skid_load = 1'b1;
            w_state_d   = StTwo;
          end
        end
        StTwo: begin
          if (w_pop) begin
            w_main_from_skid = 1'b1;
            w_state_d        = StOne;
          end
        end
        default: w_state_d = StEmpty;
      endcase
    end
  end

  // State, valid bits and the registered in_ready follow the decoded next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= StEmpty;
      r_in_ready <= 1'b1;
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_in_ready <= (w_state_d != StTwo);
      r_main_vld <= (w_state_d != StEmpty);
      r_skid_vld <= (w_state_d == StTwo);
    end
  end

  // Slot payloads; flush leaves these untouched since only the valid bits matter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_main_data <= '0;
      r_main_rd   <= '0;
      r_main_wen  <= 1'b0;
      r_skid_data <= '0;
      r_skid_rd   <= '0;
      r_skid_wen  <= 1'b0;
    end else begin
      if (w_main_load) begin
        r_main_data <= i_in_data;
        r_main_rd   <= i_in_rd;
        r_main_wen  <= i_in_wen;
      end else if (w_main_from_skid) begin
        r_main_data <= r_skid_data;
        r_main_rd   <= r_skid_rd;
        r_main_wen  <= r_skid_wen;
      end
      if (w_skid_load) begin
        r_skid_data <= i_in_data;
        r_skid_rd   <= i_in_rd;
        r_skid_wen  <= i_in_wen;
      end
    end
  end

  // Saturating count of cycles where the head is held by downstream; flush does not touch it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cnt <= '0;
    end else if (r_main_vld && !i_out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  // Occupancy mirrors the state encoding.
  always_comb begin
    o_occupancy = 2'd0;
    unique case (r_state)
      StEmpty: o_occupancy = 2'd0;
      StOne:   o_occupancy = 2'd1;
      StTwo:   o_occupancy = 2'd2;
      default: o_occupancy = 2'd0;
    endcase
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_main_vld;
  assign o_out_data  = r_main_data;
  assign o_out_rd    = r_main_rd;
  assign o_out_wen   = r_main_wen && r_main_vld;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed vector table plus hand-written sequences for flush, async reset, counter
// saturation and a randomised scoreboard run.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [43:0] in_data;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic        out_valid;
  logic        out_ready;
  logic [43:0] out_data;
  logic [4:0]  out_rd;
  logic        out_wen;
  logic [1:0]  occ;
  logic [15:0] stall_cnt;

  logic        s_in_ready;
  logic        s_out_valid;
  logic [43:0] s_out_data;
  logic [4:0]  s_out_rd;
  logic        s_out_wen;
  logic [1:0]  s_occ;
  logic [3:0]  s_stall_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.PAYLOAD_W(44), .RD_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .rstn(rstn), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_data(in_data), .i_in_rd(in_rd), .i_in_wen(in_wen), .o_out_valid(out_valid),
    .i_out_ready(out_ready), .o_out_data(out_data), .o_out_rd(out_rd), .o_out_wen(out_wen),
    .o_occupancy(occ), .o_stall_cnt(stall_cnt)
  );

  pipe_skid_stage #(.PAYLOAD_W(44), .RD_W(5), .CNT_W(4)) u_sat (
    .clk(clk), .rstn(rstn), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(s_in_ready),
    .i_in_data(in_data), .i_in_rd(in_rd), .i_in_wen(in_wen), .o_out_valid(s_out_valid),
    .i_out_ready(out_ready), .o_out_data(s_out_data), .o_out_rd(s_out_rd),
    .o_out_wen(s_out_wen), .o_occupancy(s_occ), .o_stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic        fl;
    logic        iv;
    logic [43:0] d;
    logic [4:0]  rd;
    logic        wen;
    logic        ordy;
    logic        ov;
    logic [43:0] od;
    logic [4:0]  orr;
    logic        ow;
    logic [1:0]  occ;
    logic        ir;
    logic [15:0] sc;
  } vec_t;

  typedef struct {
    logic [43:0] d;
    logic [4:0]  rd;
    logic        wen;
  } ent_t;

  vec_t vecs[18];
  ent_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_rd     = '0;
    in_wen    = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    step();
  endtask

  initial begin
    logic [63:0] r;
    ent_t        e;
    ent_t        h;
    logic        acc;
    int          n_del;

    //          fl    iv    d       rd     wen   ordy | ov    od      orr    ow    occ   ir    sc
    vecs[0]  = '{1'b0, 1'b1, 44'h1,  5'd1,  1'b1, 1'b1, 1'b1, 44'h1,  5'd1,  1'b1, 2'd1, 1'b1, 16'd0};
    vecs[1]  = '{1'b0, 1'b1, 44'h2,  5'd2,  1'b0, 1'b1, 1'b1, 44'h2,  5'd2,  1'b0, 2'd1, 1'b1, 16'd0};
    vecs[2]  = '{1'b0, 1'b1, 44'h3,  5'd3,  1'b1, 1'b1, 1'b1, 44'h3,  5'd3,  1'b1, 2'd1, 1'b1, 16'd0};
    vecs[3]  = '{1'b0, 1'b0, 44'h0,  5'd0,  1'b0, 1'b1, 1'b0, 44'h0,  5'd0,  1'b0, 2'd0, 1'b1, 16'd0};
    vecs[4]  = '{1'b0, 1'b1, 44'hA,  5'd10, 1'b1, 1'b0, 1'b1, 44'hA,  5'd10, 1'b1, 2'd1, 1'b1, 16'd0};
    vecs[5]  = '{1'b0, 1'b1, 44'hB,  5'd11, 1'b1, 1'b0, 1'b1, 44'hA,  5'd10, 1'b1, 2'd2, 1'b0, 16'd1};
    vecs[6]  = '{1'b0, 1'b1, 44'hD,  5'd13, 1'b1, 1'b0, 1'b1, 44'hA,  5'd10, 1'b1, 2'd2, 1'b0, 16'd2};
    vecs[7]  = '{1'b0, 1'b0, 44'h0,  5'd0,  1'b0, 1'b0, 1'b1, 44'hA,  5'd10, 1'b1, 2'd2, 1'b0, 16'd3};
    vecs[8]  = '{1'b0, 1'b0, 44'h0,  5'd0,  1'b0, 1'b1, 1'b1, 44'hB,  5'd11, 1'b1, 2'd1, 1'b1, 16'd3};
    vecs[9]  = '{1'b0, 1'b0, 44'h0,  5'd0,  1'b0, 1'b1, 1'b0, 44'h0,  5'd0,  1'b0, 2'd0, 1'b1, 16'd3};
    vecs[10] = '{1'b0, 1'b1, 44'h11, 5'd1,  1'b1, 1'b0, 1'b1, 44'h11, 5'd1,  1'b1, 2'd1, 1'b1, 16'd3};
    vecs[11] = '{1'b0, 1'b1, 44'h12, 5'd2,  1'b1, 1'b0, 1'b1, 44'h11, 5'd1,  1'b1, 2'd2, 1'b0, 16'd4};
    vecs[12] = '{1'b1, 1'b1, 44'hC,  5'd12, 1'b1, 1'b0, 1'b0, 44'h0,  5'd0,  1'b0, 2'd0, 1'b1, 16'd5};
    vecs[13] = '{1'b0, 1'b0, 44'h0,  5'd0,  1'b0, 1'b1, 1'b0, 44'h0,  5'd0,  1'b0, 2'd0, 1'b1, 16'd5};
    vecs[14] = '{1'b0, 1'b1, 44'h21, 5'd4,  1'b1, 1'b1, 1'b1, 44'h21, 5'd4,  1'b1, 2'd1, 1'b1, 16'd5};
    vecs[15] = '{1'b1, 1'b1, 44'h22, 5'd5,  1'b1, 1'b1, 1'b0, 44'h0,  5'd0,  1'b0, 2'd0, 1'b1, 16'd5};
    vecs[16] = '{1'b0, 1'b1, 44'h23, 5'd3,  1'b0, 1'b1, 1'b1, 44'h23, 5'd3,  1'b0, 2'd1, 1'b1, 16'd5};
    vecs[17] = '{1'b0, 1'b0, 44'h0,  5'd0,  1'b0, 1'b1, 1'b0, 44'h0,  5'd0,  1'b0, 2'd0, 1'b1, 16'd5};

    // Reset values.
    idle_inputs();
    rstn = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_wen", 64'(out_wen), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_rd", 64'(out_rd), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    step();

    // Table-driven streaming, back-pressure and flush vectors.
    for (int i = 0; i < 18; i++) begin
      flush     = vecs[i].fl;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      in_rd     = vecs[i].rd;
      in_wen    = vecs[i].wen;
      out_ready = vecs[i].ordy;
      step();
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
      chk($sformatf("v%0d_out_wen", i), 64'(out_wen), 64'(vecs[i].ow));
      chk($sformatf("v%0d_occ", i), 64'(occ), 64'(vecs[i].occ));
      chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].ir));
      chk($sformatf("v%0d_stall_cnt", i), 64'(stall_cnt), 64'(vecs[i].sc));
      if (vecs[i].ov) begin
        chk($sformatf("v%0d_out_data", i), 64'(out_data), 64'(vecs[i].od));
        chk($sformatf("v%0d_out_rd", i), 64'(out_rd), 64'(vecs[i].orr));
      end
    end

    // Async reset mid-cycle while holding two entries.
    idle_inputs();
    in_valid = 1'b1; in_data = 44'h31; in_wen = 1'b1;
    step();
    in_data = 44'h32;
    step();
    in_valid = 1'b0;
    chk("ar_pre_occ", 64'(occ), 64'd2);
    #3;
    rstn = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_out_wen", 64'(out_wen), 64'd0);
    chk("ar_out_data", 64'(out_data), 64'd0);
    chk("ar_occ", 64'(occ), 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    chk("ar_stall_cnt", 64'(stall_cnt), 64'd0);
    #2;
    rstn = 1'b1;
    step();
    in_valid = 1'b1; in_data = 44'h5; in_rd = 5'd7; in_wen = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ar_post_valid", 64'(out_valid), 64'd1);
    chk("ar_post_data", 64'(out_data), 64'h5);
    chk("ar_post_rd", 64'(out_rd), 64'd7);

    // Stall counter saturation on the 4-bit instance, 20 stalled cycles.
    idle_inputs();
    pulse_reset();
    in_valid = 1'b1; in_data = 44'h40;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      chk($sformatf("sat4_c%0d", i), 64'(s_stall_cnt), (i < 15) ? 64'(i) : 64'd15);
      chk($sformatf("cnt16_c%0d", i), 64'(stall_cnt), 64'(i));
    end
    chk("sat_hold_data", 64'(out_data), 64'h40);

    // Randomised valid/ready/flush against a queue scoreboard.
    idle_inputs();
    pulse_reset();
    sb.delete();
    n_del = 0;
    for (int c = 0; c < 600; c++) begin
      r         = {$urandom, $urandom};
      in_data   = r[43:0];
      in_rd     = 5'($urandom_range(31));
      in_wen    = 1'($urandom_range(1));
      in_valid  = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      flush     = ($urandom_range(99) < 5);
      @(negedge clk);
      chk("rnd_in_ready", 64'(in_ready), 64'(sb.size() < 2));
      chk("rnd_occ", 64'(occ), 64'(sb.size()));
      acc = in_valid && (sb.size() < 2);
      if (flush) begin
        sb.delete();
      end else begin
        if (out_ready && (sb.size() > 0)) begin
          h = sb.pop_front();
          chk("rnd_data", 64'(out_data), 64'(h.d));
          chk("rnd_rd", 64'(out_rd), 64'(h.rd));
          chk("rnd_wen", 64'(out_wen), 64'(h.wen));
          n_del++;
        end
        if (acc) begin
          e.d = in_data; e.rd = in_rd; e.wen = in_wen;
          sb.push_back(e);
        end
      end
      step();
    end
    chk("rnd_some_delivered", 64'(n_del > 50), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

Interface
REQ-001 Parameter PAYLOAD_W, default 44, SHALL set the width of the opaque stage payload (alu result, store data, func3, mem controls).
REQ-002 Parameter RD_W, default 5, SHALL set the destination-register field width.
REQ-003 Parameter CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 flush  in  1  kill all held entries.
REQ-007 in_valid  in  1  upstream offers an entry.
REQ-008 in_ready  out  1  stage accepts an entry this cycle.
REQ-009 in_data  in  PAYLOAD_W  upstream payload.
REQ-010 in_rd  in  RD_W  upstream destination register.
REQ-011 in_wen  in  1  upstream register-write enable.
REQ-012 out_valid  out  1  head entry present.
REQ-013 out_ready  in  1  downstream consumes the head entry.
REQ-014 out_data  out  PAYLOAD_W  head payload.
REQ-015 out_rd  out  RD_W  head destination register.
REQ-016 out_wen  out  1  head write enable, gated by out_valid.
REQ-017 occupancy  out  2  number of held entries, 0..2.
REQ-018 stall_cnt  out  CNT_W  saturating count of back-pressured cycles.

Function
REQ-019 Storage SHALL be two slots: MAIN (drives out_*) and SKID, each holding data, rd, wen and a valid bit.
REQ-020 States SHALL be EMPTY (no valid slot), ONE (MAIN valid only), and TWO (both valid); occupancy SHALL equal 0, 1 and 2 respectively.
REQ-021 in_ready SHALL be a registered signal equal to 1 in EMPTY and ONE and 0 in TWO, with no combinational path from out_ready.
REQ-022 Accept SHALL mean in_valid && in_ready; pop SHALL mean out_valid && out_ready.
REQ-023 In EMPTY, accept SHALL load MAIN and go to ONE, so that entry appears on out_* exactly 1 cycle after acceptance.
REQ-024 In ONE, accept with pop SHALL load MAIN and stay in ONE; pop only SHALL go to EMPTY; accept only SHALL load SKID and go to TWO.
REQ-025 In TWO, pop SHALL move SKID into MAIN and go to ONE; with no pop the state SHALL hold.
REQ-026 Ordering SHALL be strictly FIFO: no entry is dropped, duplicated or reordered except by flush.
REQ-027 flush SHALL take priority over every other event: next state EMPTY, both valid bits cleared, any same-cycle input discarded, and in_ready = 1 in the following cycle.
REQ-028 flush SHALL clear only the valid bits; data and rd contents may be retained.
REQ-029 out_wen SHALL equal MAIN.wen && MAIN.valid, so a flushed or empty stage never requests a register write.
REQ-030 stall_cnt SHALL increment by 1 on each cycle with out_valid && !out_ready, saturate at all-ones, and be unaffected by flush.
REQ-031 out_data, out_rd and out_wen SHALL hold stable while out_valid && !out_ready.

Reset
REQ-032 On rstn low, with no clock edge required, the state SHALL be EMPTY and all slot fields, out_valid, out_wen, out_data, out_rd, occupancy and stall_cnt SHALL be 0, with in_ready = 1.
REQ-033 Reset asserted mid-operation SHALL discard all held entries; the first entry accepted after deassertion SHALL appear on out_* 1 cycle later.

Verification
REQ-034 Streaming: out_ready = 1 and back-to-back in_data 0x1,0x2,0x3 -> out_data 0x1,0x2,0x3 on consecutive cycles, each 1 cycle after acceptance, occupancy 1, stall_cnt 0.
REQ-035 Back-pressure: out_ready = 0 while 0xA and 0xB are accepted -> occupancy 2, in_ready 0, out_data 0xA held, stall_cnt increments each cycle; out_ready = 1 -> 0xA then 0xB, in_ready returns to 1.
REQ-036 Flush in TWO with in_valid = 1 carrying 0xC -> next cycle out_valid 0, out_wen 0, occupancy 0, in_ready 1, and 0xC is never output.
REQ-037 Saturation: CNT_W = 4 with 20 stalled cycles -> stall_cnt stays at 0xF.
REQ-038 Async reset pulsed mid-cycle while in TWO -> outputs 0 immediately with in_ready 1; after release, accepted 0x5 appears 1 cycle later.
REQ-039 Randomised valid/ready, flush probability 5%, PAYLOAD_W = 44 and RD_W = 5 -> scoreboard confirms in-order, loss-free delivery of every non-flushed entry.
